axi_burst_read_master: RTL and testbench

Command-driven AXI4 read master that sits directly upstream of the AXI slave RAM on the read address/data channels. Accepts one burst command at a time, issues a single INCR burst on AR, collects the R beats into an internal FIFO and presents them as a valid/ready stream with a last marker. Write channels are out of scope for this block.

---
 rtl/axi_burst_read_master.sv | 155 +++++++++++++++
 tb/tb_axi_burst_read_master.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_read_master.sv
// AXI4 read master: takes one burst command at a time, issues a single INCR burst on AR,
// and buffers the R beats in a small FIFO exposed as a valid/ready stream with a last marker.
module axi_burst_read_master #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [7:0]               cmd_len,
  input  logic [2:0]               cmd_size,
  output logic [ADDRESS_WIDTH-1:0] araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [DATA_WIDTH-1:0]    rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     done,
  output logic                     err
);

  localparam int          PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [31:0] BEAT_BYTES = 32'(DATA_WIDTH / 8);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]               r_state;
  logic [ADDRESS_WIDTH-1:0] r_araddr;
  logic [7:0]               r_arlen;
  logic [2:0]               r_arsize;
  logic [8:0]               r_cnt;
  logic                     r_err;
  logic                     r_done;

  logic [PTR_W:0]           r_wptr;
  logic [PTR_W:0]           r_rptr;
  logic [DATA_WIDTH-1:0]    r_mem_data [FIFO_DEPTH];
  logic                     r_mem_last [FIFO_DEPTH];

  logic w_size_ok;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_beat_last;
  logic w_unused;

  // Framing comes from the beat counter alone; the slave's rlast is deliberately not trusted.
  assign w_unused = rlast;

  assign w_size_ok   = (32'd1 << cmd_size) <= BEAT_BYTES;
  assign w_beat_last = (r_cnt == {1'b0, r_arlen});

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);

  assign cmd_ready = (r_state == S_IDLE) && !areset;
  assign arvalid   = (r_state == S_ADDR);
  assign arburst   = 2'b01;
  assign araddr    = r_araddr;
  assign arlen     = r_arlen;
  assign arsize    = r_arsize;

  // rready looks only at state and occupancy, so a full FIFO stalls R even while it is popping.
  assign rready = (r_state == S_DATA) && !w_full;
  assign w_push = rvalid && rready;
  assign w_pop  = out_valid && out_ready;

  assign out_valid = !w_empty;
  assign out_data  = r_mem_data[r_rptr[PTR_W-1:0]];
  assign out_last  = !w_empty && r_mem_last[r_rptr[PTR_W-1:0]];
  assign done      = r_done;
  assign err       = r_err;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state  <= S_IDLE;
      r_araddr <= '0;
      r_arlen  <= '0;
      r_arsize <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            r_araddr <= cmd_addr;
            r_arlen  <= cmd_len;
            r_arsize <= cmd_size;
            r_cnt    <= '0;
            if (w_size_ok) begin
              r_err   <= 1'b0;
              r_state <= S_ADDR;
            end else begin
              // Oversized beats are refused locally: flag and finish without touching AR.
              r_err  <= 1'b1;
              r_done <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (arready) r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_push) begin
            r_cnt <= r_cnt + 9'd1;
            if (rresp != 2'b00) r_err <= 1'b1;
            if (w_beat_last) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (PTR_W + 1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (PTR_W + 1)'(1);
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_mem_data[r_wptr[PTR_W-1:0]] <= rdata;
      r_mem_last[r_wptr[PTR_W-1:0]] <= w_beat_last;
    end
  end

endmodule

// File: tb/tb_axi_burst_read_master.sv
// Bench for axi_burst_read_master: randomized AXI slave plus a transaction-level model of
// expected beats, done pulses, error flag and FIFO occupancy.
module tb_axi_burst_read_master;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 4;

  logic          aclk = 1'b0;
  logic          areset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [2:0]    cmd_size;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic          done;
  logic          err;

  always #5 aclk = ~aclk;

  axi_burst_read_master #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .done(done), .err(err)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    int         err_beat;
  } cmd_t;

  logic [7:0] ram [256];
  beat_t      exp_q [$];
  cmd_t       cmd_q [$];
  cmd_t       s_cmd;
  bit         s_active;
  int         s_beat;
  logic [7:0] s_addr;
  int         occ;
  bit         pend_done;
  bit         exp_err;
  int         n_done;
  int         ready_mode;
  int         tb_err_beat;
  bit         reset_seen;
  bit         ar_hs, r_hs, pop, c_hs;
  logic [31:0] last_pop_data;
  logic [7:0]  last_arlen;

  initial for (int i = 0; i < 256; i++) ram[i] = 8'(i);

  // Slave returns the full aligned 32-bit word containing the beat address.
  function automatic logic [31:0] word_at(input logic [7:0] a);
    logic [7:0] b;
    b = a & 8'hFC;
    return {ram[b + 8'd3], ram[b + 8'd2], ram[b + 8'd1], ram[b]};
  endfunction

  // Sample at negedge (checks reflect the last edge, then model the coming edge); drive at posedge+1.
  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; out_ready = 1'b0;
    s_active = 0; occ = 0; pend_done = 0; exp_err = 0; n_done = 0; s_beat = 0; s_addr = '0;
    forever begin
      beat_t e;
      @(negedge aclk);
      if (areset) begin
        check("cmd_ready_in_reset", cmd_ready, 0);
        exp_q.delete();
        cmd_q.delete();
        s_active = 0; occ = 0; pend_done = 0; exp_err = 0;
        r_hs = 0; reset_seen = 1;
      end else begin
        reset_seen = 0;
        if (done || pend_done) check("done", done, pend_done);
        if (done) n_done++;
        check("err", err, exp_err);
        check("out_valid", out_valid, occ > 0);
        check("rready", rready, s_active && occ < DEPTH);
        check("cmd_ready", cmd_ready, !s_active && cmd_q.size() == 0);
        check("arvalid", arvalid, cmd_q.size() != 0);
        if (arvalid && cmd_q.size() != 0) begin
          check("araddr", araddr, cmd_q[0].addr);
          check("arlen", arlen, cmd_q[0].len);
          check("arsize", arsize, cmd_q[0].size);
          check("arburst", arburst, 2'b01);
        end

        pend_done = 0;
        ar_hs = arvalid && arready;
        r_hs  = rvalid && rready;
        pop   = out_valid && out_ready;
        c_hs  = cmd_valid && cmd_ready;

        if (pop) begin
          if (exp_q.size() == 0) check("pop_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_last", out_last, e.last);
            last_pop_data = out_data;
            occ--;
          end
        end
        if (r_hs) begin
          if (!s_active) check("r_unexpected", 1, 0);
          else begin
            occ++;
            if (rresp != 2'b00) exp_err = 1;
            if (s_beat == int'(s_cmd.len)) begin
              pend_done = 1;
              s_active  = 0;
            end
            s_beat++;
            s_addr = s_addr + (8'd1 << s_cmd.size);
          end
        end
        if (ar_hs && cmd_q.size() != 0) begin
          s_cmd      = cmd_q.pop_front();
          s_active   = 1;
          s_beat     = 0;
          s_addr     = s_cmd.addr;
          last_arlen = arlen;
        end
        if (c_hs) begin
          if (cmd_size <= 3'd2) begin
            cmd_t c;
            c.addr = cmd_addr; c.len = cmd_len; c.size = cmd_size; c.err_beat = tb_err_beat;
            cmd_q.push_back(c);
            for (int k = 0; k <= int'(cmd_len); k++) begin
              e.data = word_at(8'(int'(cmd_addr) + k * (1 << cmd_size)));
              e.last = (k == int'(cmd_len));
              exp_q.push_back(e);
            end
            exp_err = 0;
          end else begin
            exp_err   = 1;
            pend_done = 1;
          end
        end
      end

      @(posedge aclk);
      #1;
      if (reset_seen) rvalid = 1'b0;
      else if (r_hs || !rvalid) begin
        if (s_active && $urandom_range(0, 99) < 70) begin
          rvalid = 1'b1;
          rdata  = word_at(s_addr);
          rresp  = (s_beat == s_cmd.err_beat) ? 2'b10 : 2'b00;
          rlast  = (s_beat == int'(s_cmd.len));
        end else rvalid = 1'b0;
      end
      arready   = 1'($urandom_range(0, 1));
      out_ready = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(0, 1) == 1);
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] a, input logic [7:0] l, input logic [2:0] s);
    bit hs;
    bit ok;
    ok = 0;
    cmd_addr = a; cmd_len = l; cmd_size = s; cmd_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge aclk);
      hs = cmd_ready;
      tick();
      if (hs) begin
        ok = 1;
        break;
      end
    end
    cmd_valid = 1'b0;
    if (!ok) check("cmd_timeout", 0, 1);
  endtask

  task automatic wait_done(input int n0, input bit drain);
    bit ok;
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      if (n_done > n0 && (!drain || (exp_q.size() == 0 && occ == 0))) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) check("done_timeout", 0, 1);
  endtask

  initial begin
    int  n0;
    bit  ok;
    logic [7:0] len;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
    ready_mode = 1; tb_err_beat = -1;
    areset = 1'b1;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_arvalid", arvalid, 0);
    check("rst_araddr", araddr, 0);
    check("rst_arlen", arlen, 0);
    check("rst_arsize", arsize, 0);
    check("rst_rready", rready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    tick();
    areset = 1'b0;
    repeat (2) tick();

    // Single-beat burst
    n0 = n_done;
    send_cmd(8'h10, 8'd0, 3'd2);
    wait_done(n0, 1);
    repeat (3) tick();
    check("t1_data", last_pop_data, 32'h13121110);
    check("t1_done_count", n_done - n0, 1);
    check("t1_err", err, 0);

    // Four-beat burst
    n0 = n_done;
    send_cmd(8'h20, 8'd3, 3'd2);
    wait_done(n0, 1);
    check("t2_last_data", last_pop_data, 32'h2F2E2D2C);
    check("t2_arlen", last_arlen, 3);

    // Backpressure: FIFO fills to depth, then drains in order
    n0 = n_done;
    ready_mode = 0;
    send_cmd(8'h40, 8'd7, 3'd2);
    repeat (40) tick();
    check("t3_beats_accepted", s_beat, DEPTH);
    check("t3_rready_full", rready, 0);
    check("t3_out_valid", out_valid, 1);
    check("t3_no_done_yet", n_done - n0, 0);
    ready_mode = 1;
    wait_done(n0, 1);
    check("t3_last_data", last_pop_data, 32'h5F5E5D5C);

    // Illegal size, then a legal command clears err
    n0 = n_done;
    send_cmd(8'h30, 8'd0, 3'd3);
    repeat (3) tick();
    check("t4_err", err, 1);
    check("t4_done_count", n_done - n0, 1);
    n0 = n_done;
    send_cmd(8'h30, 8'd0, 3'd2);
    wait_done(n0, 1);
    check("t4_err_cleared", err, 0);

    // Error response on beat 2 of 4
    n0 = n_done;
    tb_err_beat = 1;
    send_cmd(8'h80, 8'd3, 3'd2);
    wait_done(n0, 1);
    repeat (3) tick();
    check("t5_err_sticky", err, 1);
    tb_err_beat = -1;

    // Reset mid-burst
    ready_mode = 2;
    send_cmd(8'h00, 8'd7, 3'd2);
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      if (s_active && s_beat >= 2) begin
        ok = 1;
        break;
      end
      tick();
    end
    check("t6_reached_beat2", ok, 1);
    n0 = n_done;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    @(negedge aclk);
    check("t6_out_valid", out_valid, 0);
    check("t6_arvalid", arvalid, 0);
    check("t6_rready", rready, 0);
    check("t6_done", done, 0);
    tick();
    check("t6_no_done", n_done - n0, 0);
    n0 = n_done;
    send_cmd(8'hC4, 8'd5, 3'd2);
    wait_done(n0, 1);

    // Randomized commands, alternately overlapping with an undrained FIFO
    for (int it = 0; it < 40; it++) begin
      len = 8'($urandom_range(0, 12));
      tb_err_beat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(len))) : -1;
      n0 = n_done;
      send_cmd(8'($urandom_range(0, 255)), len, 3'($urandom_range(0, 3)));
      wait_done(n0, it[0]);
    end
    tb_err_beat = -1;
    n0 = n_done - 1;
    wait_done(n0, 1);

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
